// File: rtl/prog_slowclk_if.sv
// prog_slowclk_if: rate-select, enable and slow-clock status bundle of the slow-clock generator.
interface prog_slowclk_if #(
  parameter int SEL_W = 2
);
  logic [SEL_W-1:0] sw;
  logic             en;
  logic             slowclk;
  logic             tick;
  logic [SEL_W-1:0] active_sel;
  logic             sel_pending;
  modport master (output sw, en, input slowclk, tick, active_sel, sel_pending);
  modport slave  (input sw, en, output slowclk, tick, active_sel, sel_pending);
endinterface

// File: rtl/prog_slowclk.sv
// prog_slowclk: power-of-two fastclk divider with glitch-free run-time rate select and rising-edge tick.
module prog_slowclk #(
  parameter int CNT_W    = 27,
  parameter int SEL_W    = 2,
  parameter int BASE_EXP = 24
) (
  input logic           fastclk,
  input logic           rst_n,
  prog_slowclk_if.slave bus
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  logic [SEL_W-1:0] sync1;
  logic [SEL_W-1:0] sw_s;
  logic [SEL_W-1:0] act;
  logic             slow;
  logic             tick;
  assign lim = (CNT_W'(1) << (BASE_EXP + int'(act))) - CNT_W'(1);
  // rate is only swapped on the falling toggle so a full period never mixes rates
  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      slow  <= 1'b0;
      tick  <= 1'b0;
      act   <= '0;
      sync1 <= '0;
      sw_s  <= '0;
    end else begin
      sync1 <= bus.sw;
      sw_s  <= sync1;
      tick  <= 1'b0;
      if (bus.en) begin
        if (cnt == lim) begin
          cnt  <= '0;
          slow <= ~slow;
          tick <= ~slow;
          if (slow) act <= sw_s;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
  assign bus.slowclk     = slow;
  assign bus.tick        = tick;
  assign bus.active_sel  = act;
  assign bus.sel_pending = sw_s != act;
endmodule

// File: tb/tb_prog_slowclk.sv
// tb_prog_slowclk: randomized scoreboard bench for prog_slowclk against a phase-length reference model.
module tb_prog_slowclk;
  localparam int BE = 2;
  typedef struct packed {
    logic       s;
    logic       t;
    logic [1:0] a;
    logic       p;
  } exp_t;
  logic fastclk = 1'b0;
  logic rst_n;
  prog_slowclk_if #(.SEL_W(2)) bus ();
  prog_slowclk #(.CNT_W(8), .SEL_W(2), .BASE_EXP(BE)) dut (
    .fastclk (fastclk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );
  always #5 fastclk = ~fastclk;
  exp_t q[$];
  int vectors = 0;
  int errs = 0;
  logic       m_lvl;
  logic [1:0] m_sel;
  int         m_left;
  logic [1:0] m_h1, m_h2;
  int         edge_n;
  // model: each phase lasts 2**(BE+sel) enabled edges; sw seen by the divider lags two samples
  task automatic model_reset();
    m_lvl = 1'b0; m_sel = 2'd0; m_left = 1 << BE; m_h1 = 2'd0; m_h2 = 2'd0; edge_n = 0;
  endtask
  task automatic model_edge(input logic [1:0] s, input logic e);
    exp_t x;
    x.t = 1'b0;
    edge_n++;
    if (e) begin
      m_left--;
      if (m_left == 0) begin
        if (m_lvl) m_sel = m_h2;
        m_lvl  = ~m_lvl;
        x.t    = m_lvl;
        m_left = 1 << (BE + int'(m_sel));
      end
    end
    m_h2 = m_h1;
    m_h1 = s;
    x.s = m_lvl;
    x.a = m_sel;
    x.p = m_h2 != m_sel;
    q.push_back(x);
  endtask
  task automatic step(input logic [1:0] s, input logic e);
    bus.sw = s;
    bus.en = e;
    @(posedge fastclk);
    model_edge(s, e);
    @(negedge fastclk);
  endtask
  task automatic chk_reset(input string nm);
    vectors++;
    if ({bus.slowclk, bus.tick, bus.active_sel, bus.sel_pending} !== 5'b0) begin
      errs++;
      $display("FAIL %s: got s=%b t=%b a=%0d p=%b, expected all zero", nm,
               bus.slowclk, bus.tick, bus.active_sel, bus.sel_pending);
    end
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    model_reset();
    @(negedge fastclk);
    @(negedge fastclk);
    rst_n = 1'b1;
  endtask
  always @(posedge fastclk) begin
    exp_t e, g;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      g = {bus.slowclk, bus.tick, bus.active_sel, bus.sel_pending};
      vectors++;
      if (g !== e) begin
        errs++;
        $display("FAIL out @%0t: got s=%b t=%b a=%0d p=%b, expected s=%b t=%b a=%0d p=%b",
                 $time, g.s, g.t, g.a, g.p, e.s, e.t, e.a, e.p);
      end
    end
  end
  initial begin
    logic [1:0] s;
    rst_n = 1'b0; bus.sw = 2'd0; bus.en = 1'b0;
    model_reset();
    #1 chk_reset("power_on_reset");
    @(negedge fastclk);
    @(negedge fastclk);
    rst_n = 1'b1;
    repeat (24) step(2'd0, 1'b1);
    repeat (5) step(2'd0, 1'b1);
    repeat (40) step(2'd1, 1'b1);
    repeat (4) step(2'd1, 1'b1);
    repeat (10) step(2'd1, 1'b0);
    repeat (30) step(2'd1, 1'b1);
    async_reset();
    repeat (160) step(2'd3, 1'b1);
    repeat (3) step(2'd3, 1'b1);
    repeat (10) step(2'd3, 1'b0);
    repeat (60) step(2'd3, 1'b1);
    async_reset();
    repeat (5) step(2'd0, 1'b1);
    repeat (2) step(2'd2, 1'b1);
    repeat (40) step(2'd1, 1'b1);
    s = 2'd0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(15) == 0) s = 2'($urandom_range(3));
      step(s, $urandom_range(9) != 0);
      if (i == 450) async_reset();
    end
    repeat (2) @(posedge fastclk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
